cntr_udmod_nb: RTL

Parametrised n-bit up/down counter with programmable terminal value, wrap or saturate mode, an integrated clock-enable prescaler, and a registered terminal-count pulse. It replaces the single-direction up/hold counter as the general counting primitive for timers, baud/tick generators and address sequencers in the driver modules. It runs in one clock domain.

---
 rtl/cntr_pkg.sv | 9 +
 rtl/prescale_tick_nb.sv | 35 +++
 rtl/cntr_udmod_nb.sv | 89 ++++++++
 3 files changed

// File: rtl/cntr_pkg.sv
// Shared encodings for the up/down counter family and the blocks that drive it.
package cntr_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage : cntr_pkg

// File: rtl/prescale_tick_nb.sv
// Clock-enable prescaler: emits one tick every div+1 enabled cycles.
// Reusable by any block that needs a programmable-rate strobe.
module prescale_tick_nb #(
    parameter int p = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         restart,
    input  logic [p-1:0] div,
    output logic         tick
);

    logic [p-1:0] r_pc;
    logic         w_at_div;

    assign w_at_div = (r_pc == div);
    assign tick     = en & w_at_div;

    // If div is lowered below pc, pc runs on through 2^p and wraps to 0.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc <= '0;
        end else if (restart) begin
            r_pc <= '0;
        end else if (en) begin
            if (w_at_div) begin
                r_pc <= '0;
            end else begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

endmodule : prescale_tick_nb

// File: rtl/cntr_udmod_nb.sv
// n-bit up/down counter with programmable terminal value, wrap/saturate
// mode, built-in prescaler and a registered terminal-count pulse.
module cntr_udmod_nb
    import cntr_pkg::*;
#(
    parameter int n = 8,
    parameter int p = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    input  logic         ld,
    input  logic [n-1:0] D,
    input  logic [n-1:0] max,
    input  logic [p-1:0] div,
    output logic [n-1:0] count,
    output logic         rco,
    output logic         tc
);

    logic [n-1:0] r_count;
    logic         r_tc;
    logic         w_tick;
    logic         w_step;
    logic         w_is_up;
    logic         w_is_sat;
    logic         w_at_bound;
    logic [n-1:0] w_load_val;
    logic [n-1:0] w_step_val;

    prescale_tick_nb #(
        .p(p)
    ) u_prescale (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .restart(ld),
        .div    (div),
        .tick   (w_tick)
    );

    assign w_is_up    = (up == DIR_UP);
    assign w_is_sat   = (sat == MODE_SAT);
    assign w_step     = w_tick & ~ld;
    assign w_at_bound = w_is_up ? (r_count >= max) : (r_count == '0);
    assign w_load_val = (D > max) ? max : D;

    always_comb begin
        w_step_val = r_count;
        if (w_is_up) begin
            if (r_count < max) begin
                w_step_val = r_count + 1'b1;
            end else begin
                w_step_val = w_is_sat ? max : '0;
            end
        end else begin
            // A count left above a lowered max snaps to max before descending.
            if (r_count > max) begin
                w_step_val = max;
            end else if (r_count != '0) begin
                w_step_val = r_count - 1'b1;
            end else begin
                w_step_val = w_is_sat ? '0 : max;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (ld) begin
            r_count <= w_load_val;
            r_tc    <= 1'b0;
        end else if (w_step) begin
            r_count <= w_step_val;
            r_tc    <= w_at_bound;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign rco   = w_at_bound;

endmodule : cntr_udmod_nb
